ethstream_tx_framer: RTL and testbench

// Store-and-forward framer ahead of the Ethernet stream UDP transmitter. Buffers each

---
 rtl/ethstream_tx_framer_if.sv | 10 +
 rtl/ethstream_tx_framer.sv | 181 ++++++++++++++++++
 tb/tb_ethstream_tx_framer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ethstream_tx_framer_if.sv
// Byte-wide AXI4-Stream bundle used on both sides of the tx framer.
interface ethstream_tx_framer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ethstream_tx_framer.sv
// Store-and-forward framer: buffers user packets, splits them at MAX_LEN and
// re-emits each one as a 2-byte little-endian length followed by its payload.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | output idle; pops the next committed length when one exists
// ST_LEN_LSB | presenting cur_len[7:0]
// ST_LEN_MSB | presenting cur_len[15:8]; first payload byte fetched on handshake
// ST_DATA    | presenting payload bytes; tlast on the final one
module ethstream_tx_framer #(
  parameter int ADDR_BITS = 11,
  parameter int MAX_LEN   = 1472,
  parameter int LENQ_BITS = 2
) (
  input  logic                  clk,
  input  logic                  aresetn,
  ethstream_tx_framer_if.slave  s_axis,
  ethstream_tx_framer_if.master m_axis,
  output logic                  truncated,
  output logic [LENQ_BITS:0]    pkts_pending
);

  typedef enum logic [1:0] {ST_IDLE, ST_LEN_LSB, ST_LEN_MSB, ST_DATA} state_t;

  localparam int                   RAM_DEPTH    = 2**ADDR_BITS;
  localparam int                   LQ_DEPTH     = 2**LENQ_BITS;
  localparam logic [ADDR_BITS:0]   RAM_FULL_OCC = (ADDR_BITS+1)'(RAM_DEPTH);
  localparam logic [LENQ_BITS+1:0] LQ_FULL_OCC  = (LENQ_BITS+2)'(LQ_DEPTH);
  localparam logic [15:0]          MAX_LEN_W    = 16'(MAX_LEN);
  localparam logic [ADDR_BITS:0]   PTR_ONE      = (ADDR_BITS+1)'(1);
  localparam logic [LENQ_BITS:0]   LQ_ONE       = (LENQ_BITS+1)'(1);

  logic [7:0]           ram [RAM_DEPTH];
  logic [15:0]          lenq [LQ_DEPTH];

  logic [ADDR_BITS:0]   wr_ptr, rd_ptr, ram_occ;
  logic [LENQ_BITS:0]   lq_wr, lq_rd, lq_occ;
  logic [LENQ_BITS+1:0] lq_used;
  logic [15:0]          pkt_cnt, pkt_cnt_inc, stage_len, lq_head;
  logic                 run_q, stage_vld, s_fire, commit, ram_full, lenq_full;

  state_t               state_q, state_d;
  logic [15:0]          cur_len_q, cur_len_d, rem_q, rem_d;
  logic [7:0]           tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic                 m_fire, pop, rd_adv;
  logic [ADDR_BITS-1:0] rd_addr, rd_addr_nxt;

  // Occupancy uses one extra pointer bit so full and empty differ.
  // A staged commit already counts against the length queue so it can never overflow.
  assign ram_occ       = wr_ptr - rd_ptr;
  assign ram_full      = (ram_occ == RAM_FULL_OCC);
  assign lq_occ        = lq_wr - lq_rd;
  assign lq_used       = {1'b0, lq_occ} + {{(LENQ_BITS+1){1'b0}}, stage_vld};
  assign lenq_full     = (lq_used >= LQ_FULL_OCC);
  assign s_axis.tready = run_q && !ram_full && !lenq_full;
  assign s_fire        = s_axis.tvalid && s_axis.tready;
  assign pkt_cnt_inc   = pkt_cnt + 16'd1;
  assign commit        = s_fire && (s_axis.tlast || (pkt_cnt_inc == MAX_LEN_W));
  assign pkts_pending  = lq_occ;
  assign lq_head       = lenq[lq_rd[LENQ_BITS-1:0]];

  assign m_fire        = tvalid_q && m_axis.tready;
  assign rd_addr       = rd_ptr[ADDR_BITS-1:0];
  assign rd_addr_nxt   = rd_addr + ADDR_BITS'(1);
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;

  // Payload storage; contents only matter between rd_ptr and wr_ptr, so no reset.
  always_ff @(posedge clk) begin
    if (s_fire) ram[wr_ptr[ADDR_BITS-1:0]] <= s_axis.tdata;
  end

  // Length queue storage, written one cycle after the commit that produced it.
  always_ff @(posedge clk) begin
    if (stage_vld) lenq[lq_wr[LENQ_BITS-1:0]] <= stage_len;
  end

  // Write side: byte pointer, running packet count, commit staging and split pulse.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      run_q     <= 1'b0;
      wr_ptr    <= '0;
      pkt_cnt   <= '0;
      stage_vld <= 1'b0;
      stage_len <= '0;
      truncated <= 1'b0;
      lq_wr     <= '0;
    end else begin
      run_q     <= 1'b1;
      stage_vld <= commit;
      truncated <= commit && !s_axis.tlast;
      if (commit) stage_len <= pkt_cnt_inc;
      if (s_fire) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        pkt_cnt <= commit ? 16'd0 : pkt_cnt_inc;
      end
      if (stage_vld) lq_wr <= lq_wr + LQ_ONE;
    end
  end

  // Read FSM next state and next values of the registered stream outputs.
  // The byte after the current one is read ahead so DATA runs at one beat per cycle.
  always_comb begin
    state_d   = state_q;
    cur_len_d = cur_len_q;
    rem_d     = rem_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    pop       = 1'b0;
    rd_adv    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (lq_occ != '0) begin
          pop       = 1'b1;
          cur_len_d = lq_head;
          tdata_d   = lq_head[7:0];
          tvalid_d  = 1'b1;
          tlast_d   = 1'b0;
          state_d   = ST_LEN_LSB;
        end
      end
      ST_LEN_LSB: begin
        if (m_fire) begin
          tdata_d = cur_len_q[15:8];
          state_d = ST_LEN_MSB;
        end
      end
      ST_LEN_MSB: begin
        if (m_fire) begin
          tdata_d = ram[rd_addr];
          tlast_d = (cur_len_q == 16'd1);
          rem_d   = cur_len_q;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (m_fire) begin
          rd_adv = 1'b1;
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = 8'd0;
            state_d  = ST_IDLE;
          end else begin
            tdata_d = ram[rd_addr_nxt];
            rem_d   = rem_q - 16'd1;
            tlast_d = (rem_q == 16'd2);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read FSM state, output registers, read pointer and queue pop.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      cur_len_q <= '0;
      rem_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      rd_ptr    <= '0;
      lq_rd     <= '0;
    end else begin
      state_q   <= state_d;
      cur_len_q <= cur_len_d;
      rem_q     <= rem_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      if (rd_adv) rd_ptr <= rd_ptr + PTR_ONE;
      if (pop)    lq_rd  <= lq_rd + LQ_ONE;
    end
  end

endmodule

// File: tb/tb_ethstream_tx_framer.sv
// Bench for ethstream_tx_framer: two instances (default sizing and a small
// 16-byte / MAX_LEN=16 one) share one driver; a packet-level model predicts
// every output beat and split count.
module tb_ethstream_tx_framer;
  logic clk = 1'b0;
  logic aresetn = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  ethstream_tx_framer_if s_a ();
  ethstream_tx_framer_if m_a ();
  ethstream_tx_framer_if s_b ();
  ethstream_tx_framer_if m_b ();
  logic       trunc_a, trunc_b;
  logic [2:0] pend_a, pend_b;

  ethstream_tx_framer #(.ADDR_BITS(11), .MAX_LEN(1472), .LENQ_BITS(2)) dut_a (
    .clk(clk), .aresetn(aresetn), .s_axis(s_a), .m_axis(m_a),
    .truncated(trunc_a), .pkts_pending(pend_a));

  ethstream_tx_framer #(.ADDR_BITS(4), .MAX_LEN(16), .LENQ_BITS(2)) dut_b (
    .clk(clk), .aresetn(aresetn), .s_axis(s_b), .m_axis(m_b),
    .truncated(trunc_b), .pkts_pending(pend_b));

  logic       sel = 1'b0;
  logic [7:0] drv_tdata = 8'd0;
  logic       drv_tvalid = 1'b0, drv_tlast = 1'b0, drv_mready = 1'b0;
  logic       obs_stready, obs_mvalid, obs_mlast, obs_trunc;
  logic [7:0] obs_mdata;
  logic [2:0] obs_pend;

  assign s_a.tdata  = drv_tdata;
  assign s_a.tlast  = drv_tlast;
  assign s_a.tvalid = drv_tvalid && !sel;
  assign m_a.tready = drv_mready && !sel;
  assign s_b.tdata  = drv_tdata;
  assign s_b.tlast  = drv_tlast;
  assign s_b.tvalid = drv_tvalid && sel;
  assign m_b.tready = drv_mready && sel;

  assign obs_stready = sel ? s_b.tready : s_a.tready;
  assign obs_mvalid  = sel ? m_b.tvalid : m_a.tvalid;
  assign obs_mlast   = sel ? m_b.tlast  : m_a.tlast;
  assign obs_mdata   = sel ? m_b.tdata  : m_a.tdata;
  assign obs_trunc   = sel ? trunc_b    : trunc_a;
  assign obs_pend    = sel ? pend_b     : pend_a;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: user packets split at MAX_LEN, each emitted as len LSB, len MSB, payload.
  logic [7:0] pkt_q[$];
  logic [8:0] exp_q[$];
  int         exp_trunc = 0;

  task automatic model_accept(input logic [7:0] d, input logic l);
    int          ml;
    logic [15:0] n16;
    ml = sel ? 16 : 1472;
    pkt_q.push_back(d);
    if (l || pkt_q.size() == ml) begin
      n16 = 16'(pkt_q.size());
      exp_q.push_back({1'b0, n16[7:0]});
      exp_q.push_back({1'b0, n16[15:8]});
      for (int i = 0; i < pkt_q.size(); i++)
        exp_q.push_back({(i == pkt_q.size() - 1) ? 1'b1 : 1'b0, pkt_q[i]});
      if (!l) exp_trunc++;
      pkt_q.delete();
    end
  endtask

  // Output monitor and input acceptance tracking, sampled mid-cycle.
  int         trunc_seen = 0, run_len = 0, max_run = 0, rise_cyc = 0, n_rises = 0;
  int         rise_q[$];
  int         lastbeat_q[$];
  logic       prev_stall = 1'b0, prev_valid = 1'b0;
  logic [8:0] prev_beat = '0;

  always @(negedge clk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
      run_len    = 0;
    end else begin
      if (prev_stall)
        chk("axis_hold", {obs_mvalid, obs_mlast, obs_mdata}, {1'b1, prev_beat});
      if (obs_mvalid && !prev_valid) begin
        rise_cyc = cyc;
        n_rises++;
        rise_q.push_back(cyc);
      end
      if (obs_mvalid && drv_mready) begin
        if (exp_q.size() == 0) chk("extra_beat", {obs_mlast, obs_mdata}, 32'hFFFF_FFFF);
        else                   chk("out_beat", {obs_mlast, obs_mdata}, exp_q.pop_front());
        if (obs_mlast) lastbeat_q.push_back(cyc);
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (obs_trunc) trunc_seen++;
      if (drv_tvalid && obs_stready) model_accept(drv_tdata, drv_tlast);
      prev_stall = obs_mvalid && !drv_mready;
      prev_beat  = {obs_mlast, obs_mdata};
      prev_valid = obs_mvalid;
    end
  end

  logic rand_mode = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mode) drv_mready = 1'($urandom_range(0, 1));
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int guard;
    guard      = 0;
    drv_tdata  = d;
    drv_tlast  = l;
    drv_tvalid = 1'b1;
    @(negedge clk);
    while (!obs_stready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!obs_stready) begin
      chk("send_timeout", 0, 1);
      drv_tvalid = 1'b0;
      drv_tlast  = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    drv_tvalid = 1'b0;
    drv_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 6000) begin
      @(posedge clk);
      g++;
    end
    idle(4);
    chk(tag, exp_q.size(), 0);
  endtask

  int t_last, snap;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 aresetn = 1'b0;
    #10;
    chk("rst_a_tvalid", m_a.tvalid, 0);
    chk("rst_a_tready", s_a.tready, 0);
    chk("rst_a_pend", pend_a, 0);
    chk("rst_b_tvalid", m_b.tvalid, 0);
    chk("rst_b_trunc", trunc_b, 0);
    @(posedge clk);
    #1 aresetn = 1'b1;
    idle(3);
    chk("post_rst_tready", obs_stready, 1);

    // Short packet and commit-to-output latency
    drv_mready = 1'b1;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    t_last = cyc;
    wait_drain("t1_drain");
    chk("t1_latency", rise_cyc - t_last, 2);

    // 300-byte ramp must stream as one unbroken burst of 302 beats
    max_run = 0;
    for (int i = 0; i < 300; i++) send_byte(8'(i), i == 299);
    wait_drain("t2_drain");
    chk("t2_run", max_run, 302);

    // Back-to-back packets: exactly one empty cycle after a tlast beat
    drv_mready = 1'b0;
    rise_q.delete();
    lastbeat_q.delete();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    idle(4);
    drv_mready = 1'b1;
    wait_drain("b2b_drain");
    chk("b2b_rises", rise_q.size(), 2);
    if (rise_q.size() == 2 && lastbeat_q.size() >= 1)
      chk("b2b_gap", rise_q[1] - lastbeat_q[0], 2);

    // Length queue back-pressure with the output stalled
    drv_mready = 1'b0;
    for (int p = 0; p < 5; p++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      idle(3);
      if (p == 3) begin
        chk("t4_pend3", obs_pend, 3);
        chk("t4_ready_open", obs_stready, 1);
      end
    end
    chk("t4_pend4", obs_pend, 4);
    chk("t4_ready_shut", obs_stready, 0);
    drv_mready = 1'b1;
    wait_drain("t4_drain");
    chk("t4_pend_zero", obs_pend, 0);

    // Small instance: split at MAX_LEN, and exact-MAX_LEN packet without split
    sel = 1'b1;
    trunc_seen = 0;
    for (int i = 0; i < 20; i++) send_byte(8'($urandom_range(0, 255)), i == 19);
    wait_drain("t3_drain");
    chk("t3_trunc", trunc_seen, 1);
    trunc_seen = 0;
    for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)), i == 15);
    wait_drain("t3_exact_drain");
    chk("t3_exact_no_trunc", trunc_seen, 0);

    // Payload RAM full with output stalled, then drain and continue
    drv_mready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(8'hC0 + i), 1'b0);
    idle(3);
    chk("t5_full_tready", obs_stready, 0);
    drv_mready = 1'b1;
    for (int i = 0; i < 10; i++) send_byte(8'(8'hE0 + i), i == 9);
    wait_drain("t5_drain");
    chk("t5_tready_back", obs_stready, 1);

    // Randomized traffic on both instances with random output stalls
    for (int s = 0; s < 2; s++) begin
      int plen, gap;
      sel = (s == 1);
      trunc_seen = 0;
      exp_trunc  = 0;
      rand_mode  = 1'b1;
      for (int p = 0; p < 12; p++) begin
        plen = sel ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 200));
        for (int i = 0; i < plen; i++) begin
          send_byte(8'($urandom_range(0, 255)), i == plen - 1);
          gap = int'($urandom_range(0, 2));
          if (gap != 0) idle(gap);
        end
      end
      rand_mode = 1'b0;
      @(posedge clk);
      #2 drv_mready = 1'b1;
      wait_drain("rand_drain");
      chk("rand_trunc", trunc_seen, exp_trunc);
    end

    // Reset in the middle of a payload, then a clean restart
    sel = 1'b0;
    drv_mready = 1'b0;
    for (int i = 0; i < 10; i++) send_byte(8'(8'h70 + i), i == 9);
    for (int g = 0; g < 50 && !obs_mvalid; g++) idle(1);
    chk("t6_valid_seen", obs_mvalid, 1);
    drv_mready = 1'b1;
    idle(4);
    drv_mready = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("t6_rst_tvalid", m_a.tvalid, 0);
    chk("t6_rst_tlast", m_a.tlast, 0);
    chk("t6_rst_tdata", m_a.tdata, 0);
    chk("t6_rst_tready", s_a.tready, 0);
    chk("t6_rst_pend", pend_a, 0);
    exp_q.delete();
    pkt_q.delete();
    @(posedge clk);
    #1 aresetn = 1'b1;
    snap = n_rises;
    idle(10);
    chk("t6_quiet", n_rises - snap, 0);
    drv_mready = 1'b1;
    send_byte(8'h5A, 1'b1);
    wait_drain("t6_drain");

    chk("final_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
